div_sequencer: RTL and testbench

- Multi-cycle restoring divider controller for the ALU datapath; executes MIPS div/divu.
- Sequences one shared compare-and-subtract step per clock, WIDTH steps per operation.
- Sits beside the combinational ALU; the control unit issues start and stalls on busy.
- Results feed the HI/LO registers.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 28 ++
 rtl/div_sequencer.sv | 122 ++++++++++++
 tb/tb_div_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default sizes for the divider sequencer
package div_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring compare-and-subtract step of the divider
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;

    // Partial remainder shifted left with the next dividend bit appended.
    assign t = {rem_in, q_msb};

    // Subtract via adder with inverted divisor and carry-in of one; the carry
    // out of the low WIDTH bits is the >= compare against the divisor.
    assign diff = {1'b0, t[WIDTH-1:0]} + {1'b0, ~divisor_mag} + {{WIDTH{1'b0}}, 1'b1};

    // A set top bit of t always exceeds any WIDTH-bit divisor.
    assign q_bit   = t[WIDTH] | diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider controller for MIPS div/divu
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               nq_q, nq_d;
    logic               nr_q, nr_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   rem_o;
    logic               q_bit;
    logic [WIDTH-1:0]   q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in      (rem_q),
        .q_msb       (q_q[WIDTH-1]),
        .divisor_mag (dvs_q),
        .rem_out     (rem_o),
        .q_bit       (q_bit)
    );

    assign q_next    = {q_q[WIDTH-2:0], q_bit};
    assign busy      = state_q == RUN;
    assign done      = state_q == DONE;
    assign div_zero  = div_zero_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

    // Next-state logic: operand capture, per-step update and result load on entry to DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        nq_d        = nq_q;
        nr_d        = nr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        case (state_q)
            IDLE: if (start) begin
                nq_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                nr_d  = is_signed & dividend[WIDTH-1];
                q_d   = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
                dvs_d = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;
                rem_d = '0;
                cnt_d = CNT_W'(WIDTH);
                if (divisor == '0) begin
                    state_d     = DONE;
                    quotient_d  = '1;
                    remainder_d = dividend;
                    div_zero_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d = rem_o;
                q_d   = q_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    quotient_d  = nq_q ? -q_next : q_next;
                    remainder_d = nr_q ? -rem_o : rem_o;
                    div_zero_d  = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            nq_q        <= 1'b0;
            nr_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            nq_q        <= nq_d;
            nr_q        <= nr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized self-checking bench for div_sequencer against an arithmetic model
module tb_div_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_fail   = 0;

    div_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, truncating toward zero for signed operands.
    function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            sa = s ? longint'($signed(a)) : longint'({32'd0, a});
            sb = s ? longint'($signed(b)) : longint'({32'd0, b});
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end
    endfunction

    // Issue one operation and wait for done; optional stray start at cycle inj_k or in the done cycle.
    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input int inj_k, input bit inj_done,
                          output int lat, output int bcnt,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
        int k;
        @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        bcnt = 0;
        while (done !== 1'b1 && k < 100) begin
            if (busy === 1'b1) bcnt++;
            if (k == inj_k) begin
                start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
            end
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        lat = k;
        q   = quotient;
        r   = remainder;
        dz  = div_zero;
        if (inj_done) begin
            start = 1'b1; is_signed = 1'b0; dividend = 32'd4; divisor = 32'd2;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count done pulses and busy cycles over an idle window.
    task automatic watch(input int n, output int dones, output int busys);
        dones = 0;
        busys = 0;
        repeat (n) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busys++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, div_zero, quotient, remainder} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                     busy, done, div_zero, quotient, remainder);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed(input string name, input bit s, input logic [31:0] a, input logic [31:0] b);
        int lat, bcnt, lat_e, bcnt_e;
        logic [31:0] q, r, qe, re;
        logic dz, dze;
        model(s, a, b, qe, re, dze);
        lat_e  = dze ? 1 : 33;
        bcnt_e = dze ? 0 : 32;
        run_op(s, a, b, 0, 1'b0, lat, bcnt, q, r, dz);
        n_checks++;
        if (lat !== lat_e) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, lat_e);
        end
        n_checks++;
        if ({q, r, dz} !== {qe, re, dze}) begin
            n_fail++;
            $display("FAIL %s_result: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", name, q, r, dz, qe, re, dze);
        end
        n_checks++;
        if (bcnt !== bcnt_e) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, bcnt, bcnt_e);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_width: done still %b one cycle later, want 0", name, done);
        end
    endtask

    task automatic test_busy_start();
        int lat, bcnt, dones, busys;
        logic [31:0] q, r;
        logic dz;
        run_op(1'b0, 32'd100, 32'd7, 10, 1'b0, lat, bcnt, q, r, dz);
        n_checks++;
        if (lat !== 33 || q !== 32'd14 || r !== 32'd2) begin
            n_fail++;
            $display("FAIL busy_start_result: got lat=%0d q=%0d r=%0d want lat=33 q=14 r=2", lat, q, r);
        end
        watch(40, dones, busys);
        n_checks++;
        if (dones !== 0 || busys !== 0) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got %0d dones %0d busy cycles, want 0 and 0", dones, busys);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt, dones, busys;
        logic [31:0] q, r;
        logic dz;
        run_op(1'b0, 32'd81, 32'd9, 0, 1'b1, lat, bcnt, q, r, dz);
        n_checks++;
        if (lat !== 33 || q !== 32'd9 || r !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_result: got lat=%0d q=%0d r=%0d want lat=33 q=9 r=0", lat, q, r);
        end
        watch(40, dones, busys);
        n_checks++;
        if (dones !== 0 || busys !== 0) begin
            n_fail++;
            $display("FAIL b2b_start_at_done: got %0d dones %0d busy cycles, want 0 and 0", dones, busys);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones, busys;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_busy_before_reset: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, div_zero, quotient, remainder} !== '0) begin
            n_fail++;
            $display("FAIL midrun_async_reset: got busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                     busy, done, div_zero, quotient, remainder);
        end
        watch(3, dones, busys);
        rst_n = 1'b1;
        begin
            int d2, b2;
            watch(30, d2, b2);
            dones += d2;
            busys += b2;
        end
        n_checks++;
        if (dones !== 0 || busys !== 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %0d dones %0d busy cycles, want 0 and 0", dones, busys);
        end
        test_directed("after_reset_20_6", 1'b0, 32'd20, 32'd6);
    endtask

    task automatic test_random(input int n);
        logic [31:0] a, b;
        bit s;
        for (int i = 0; i < n; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            test_directed($sformatf("rand%0d", i), s, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed("divu_100_7", 1'b0, 32'd100, 32'd7);
        test_directed("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        test_directed("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        test_directed("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        test_directed("divu_zero_dvd", 1'b0, 32'd0, 32'd13);
        test_directed("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        test_directed("divu_1234_0", 1'b0, 32'd1234, 32'd0);
        test_directed("divu_9_3", 1'b0, 32'd9, 32'd3);
        test_directed("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
        test_busy_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
